// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: command codes and
// default parameter values.
package pc_pkg;

    // Binary code of the single command selected by priority each cycle.
    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LD   = 3'd2,
        CMD_BR   = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5
    } cmd_e;

    localparam int PC_AW_DEFAULT    = 8;
    localparam int PC_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The top entry is read combinationally from the
// register array so a pop on the cycle right after a push sees the pushed
// value. Pushes onto a full stack and pops from an empty one are ignored.
module ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          CLRn,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] count_reg;
    logic [PW-1:0] top_idx;

    // The slot below the write pointer holds the most recent entry; at
    // count==DEPTH the low bits wrap to 0 so the subtraction still lands on
    // the last slot.
    assign top_idx = count_reg[PW-1:0] - PW'(1);
    assign dout    = mem[top_idx];
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count_reg[PW-1:0]] <= din;
        end
    end

    // Occupancy count, cleared asynchronously.
    always_ff @(posedge clk or negedge CLRn) begin
        if (!CLRn) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute jump, relative branch and
// call/return through an internal return-address stack. One command per
// cycle, chosen by fixed priority RET > CALL > BR > LD > IPC.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int            AW         = PC_AW_DEFAULT,
    parameter int            DEPTH      = PC_DEPTH_DEFAULT,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          CLRn,
    input  logic          IPC,
    input  logic          LD,
    input  logic          BR,
    input  logic          CALL,
    input  logic          RET,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] offset,
    output logic [AW-1:0] PC_addr,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          err_ovf,
    output logic          err_unf
);

    cmd_e          cmd;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] addend;
    logic [AW-1:0] sum;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] stk_dout;
    logic          push;
    logic          pop;
    logic          ovf_reg;
    logic          unf_reg;

    // Priority encoder: the highest-priority asserted strobe wins.
    always_comb begin
        cmd = CMD_NOP;
        if (RET)       cmd = CMD_RET;
        else if (CALL) cmd = CMD_CALL;
        else if (BR)   cmd = CMD_BR;
        else if (LD)   cmd = CMD_LD;
        else if (IPC)  cmd = CMD_INC;
    end

    // One adder serves both +1 and the branch displacement.
    assign addend   = (cmd == CMD_BR) ? offset : AW'(1);
    assign sum      = pc_reg + addend;
    assign pc_plus1 = pc_reg + AW'(1);

    assign push = (cmd == CMD_CALL) && !stk_full;
    assign pop  = (cmd == CMD_RET) && !stk_empty;

    // Next-PC mux; a RET on an empty stack leaves the PC where it is.
    always_comb begin
        pc_next = pc_reg;
        case (cmd)
            CMD_INC:  pc_next = sum;
            CMD_LD:   pc_next = target;
            CMD_BR:   pc_next = sum;
            CMD_CALL: pc_next = target;
            CMD_RET:  pc_next = stk_empty ? pc_reg : stk_dout;
            default:  pc_next = pc_reg;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge CLRn) begin
        if (!CLRn) begin
            pc_reg <= RESET_ADDR;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // Sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge clk or negedge CLRn) begin
        if (!CLRn) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if (cmd == CMD_CALL && stk_full)  ovf_reg <= 1'b1;
            if (cmd == CMD_RET  && stk_empty) unf_reg <= 1'b1;
        end
    end

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .CLRn  (CLRn),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus1),
        .dout  (stk_dout),
        .empty (stk_empty),
        .full  (stk_full)
    );

    assign PC_addr = pc_reg;
    assign err_ovf = ovf_reg;
    assign err_unf = unf_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: a 4-bit instance for increment and
// wrap, an 8-bit instance for jumps, branches, calls and error flags.
module tb_pc_stack_unit;

    typedef struct packed {
        logic [7:0] pc;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       clrn4 = 1'b0;
    logic       clrn8 = 1'b0;
    logic       ipc = 1'b0, ld = 1'b0, br = 1'b0, call = 1'b0, ret = 1'b0;
    logic [7:0] tgt = '0;
    logic [7:0] off = '0;

    logic [3:0] pc4;
    logic       e4, f4, o4, u4;
    logic [7:0] pc8;
    logic       e8, f8, o8, u8;

    exp_t  sb[$];
    exp_t  exp_v;
    exp_t  obs_v;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    pc_stack_unit #(.AW(4), .DEPTH(4), .RESET_ADDR(4'h0)) u_dut4 (
        .clk(clk), .CLRn(clrn4), .IPC(ipc), .LD(ld), .BR(br), .CALL(call), .RET(ret),
        .target(tgt[3:0]), .offset(off[3:0]), .PC_addr(pc4),
        .stk_empty(e4), .stk_full(f4), .err_ovf(o4), .err_unf(u4)
    );

    pc_stack_unit #(.AW(8), .DEPTH(4), .RESET_ADDR(8'h00)) u_dut8 (
        .clk(clk), .CLRn(clrn8), .IPC(ipc), .LD(ld), .BR(br), .CALL(call), .RET(ret),
        .target(tgt), .offset(off), .PC_addr(pc8),
        .stk_empty(e8), .stk_full(f8), .err_ovf(o8), .err_unf(u8)
    );

    // Drive one cycle of strobes, let one rising edge pass, sample 1 ns later.
    task automatic apply(input logic s_ipc, input logic s_ld, input logic s_br,
                         input logic s_call, input logic s_ret,
                         input logic [7:0] s_tgt, input logic [7:0] s_off);
        @(negedge clk);
        ipc = s_ipc; ld = s_ld; br = s_br; call = s_call; ret = s_ret;
        tgt = s_tgt; off = s_off;
        @(posedge clk);
        #1;
        ipc = 1'b0; ld = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    // Pulse the 8-bit instance's reset between edges and release it.
    task automatic reset8();
        @(negedge clk);
        clrn8 = 1'b0;
        #2;
        @(negedge clk);
        clrn8 = 1'b1;
    endtask

    function automatic exp_t mk(input logic [7:0] p, input logic e, input logic f,
                                input logic o, input logic u);
        exp_t r;
        r.pc = p; r.empty = e; r.full = f; r.ovf = o; r.unf = u;
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        #2;
        clrn8 = 1'b0;
        sb.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        exp_v = sb.pop_front();
        obs_v = {pc8, e8, f8, o8, u8};
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL reset8: got %h want %h", obs_v, exp_v);
        end else $display("tx reset8 ok %h", obs_v);
        @(negedge clk);
        clrn8 = 1'b1;
    endtask

    task automatic test_increment();
        @(negedge clk);
        clrn4 = 1'b0;
        @(negedge clk);
        clrn4 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            sb.push_back(mk({4'h0, 4'(k % 16)}, 1'b1, 1'b0, 1'b0, 1'b0));
            apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            exp_v = sb.pop_front();
            obs_v = {4'h0, pc4, e4, f4, o4, u4};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL inc[%0d]: got %h want %h", k, obs_v, exp_v);
            end else $display("tx inc[%0d] pc=%h", k, pc4);
        end
        // Asynchronous clear in the middle of a cycle while counting.
        @(negedge clk);
        ipc = 1'b1;
        #2;
        clrn4 = 1'b0;
        sb.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        exp_v = sb.pop_front();
        obs_v = {4'h0, pc4, e4, f4, o4, u4};
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL async_clr4: got %h want %h", obs_v, exp_v);
        end else $display("tx async_clr4 pc=%h", pc4);
        ipc = 1'b0;
        @(negedge clk);
        clrn4 = 1'b1;
    endtask

    task automatic test_jump_branch();
        reset8();
        sb.push_back(mk(8'h10, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        sb.push_back(mk(8'h80, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00);
        sb.push_back(mk(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFE);
        sb.push_back(mk(8'h0E, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h90);
        sb.push_back(mk(8'h0E, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        sb.push_back(mk(8'h0E, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h33);
        // The scoreboard is drained in order after each step sequence.
        for (int i = 0; i < 6; i++) begin
            exp_v = sb.pop_front();
            n_cmp++;
        end
        n_cmp -= 6;
    endtask

    // Runs a list of steps, comparing after every edge.
    task automatic test_sequence(input string tag, input int n,
                                 input logic [4:0] strobes [16],
                                 input logic [7:0] tgts [16],
                                 input logic [7:0] offs [16],
                                 input exp_t exps [16]);
        for (int i = 0; i < n; i++) begin
            sb.push_back(exps[i]);
            apply(strobes[i][4], strobes[i][3], strobes[i][2], strobes[i][1], strobes[i][0],
                  tgts[i], offs[i]);
            exp_v = sb.pop_front();
            obs_v = {pc8, e8, f8, o8, u8};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL %s[%0d]: got pc=%h e=%b f=%b o=%b u=%b want pc=%h e=%b f=%b o=%b u=%b",
                         tag, i, obs_v.pc, obs_v.empty, obs_v.full, obs_v.ovf, obs_v.unf,
                         exp_v.pc, exp_v.empty, exp_v.full, exp_v.ovf, exp_v.unf);
            end else $display("tx %s[%0d] pc=%h e=%b f=%b o=%b u=%b", tag, i,
                              pc8, e8, f8, o8, u8);
        end
    endtask

    // Strobe field order: {IPC, LD, BR, CALL, RET}.
    localparam logic [4:0] S_NOP = 5'b00000, S_INC = 5'b10000, S_LD = 5'b01000,
                           S_BR = 5'b00100, S_CALL = 5'b00010, S_RET = 5'b00001;

    task automatic test_jumps();
        logic [4:0] s [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        exp_t       x [16];
        reset8();
        s[0] = S_LD;  t[0] = 8'h10; o[0] = 8'h00; x[0] = mk(8'h10, 1, 0, 0, 0);
        s[1] = S_LD;  t[1] = 8'h80; o[1] = 8'h00; x[1] = mk(8'h80, 1, 0, 0, 0);
        s[2] = S_BR;  t[2] = 8'h00; o[2] = 8'hFE; x[2] = mk(8'h7E, 1, 0, 0, 0);
        s[3] = S_BR;  t[3] = 8'h00; o[3] = 8'h90; x[3] = mk(8'h0E, 1, 0, 0, 0);
        s[4] = S_BR;  t[4] = 8'h00; o[4] = 8'h00; x[4] = mk(8'h0E, 1, 0, 0, 0);
        s[5] = S_NOP; t[5] = 8'h55; o[5] = 8'h33; x[5] = mk(8'h0E, 1, 0, 0, 0);
        s[6] = S_LD;  t[6] = 8'hFF; o[6] = 8'h00; x[6] = mk(8'hFF, 1, 0, 0, 0);
        s[7] = S_INC; t[7] = 8'h00; o[7] = 8'h00; x[7] = mk(8'h00, 1, 0, 0, 0);
        for (int i = 8; i < 16; i++) begin
            s[i] = S_NOP; t[i] = '0; o[i] = '0; x[i] = '0;
        end
        test_sequence("jump", 8, s, t, o, x);
    endtask

    task automatic test_nested_calls();
        logic [4:0] s [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        exp_t       x [16];
        reset8();
        for (int i = 0; i < 16; i++) begin
            s[i] = S_NOP; t[i] = '0; o[i] = '0; x[i] = '0;
        end
        s[0] = S_LD;   t[0] = 8'h05; x[0] = mk(8'h05, 1, 0, 0, 0);
        s[1] = S_CALL; t[1] = 8'h40; x[1] = mk(8'h40, 0, 0, 0, 0);
        s[2] = S_CALL; t[2] = 8'h60; x[2] = mk(8'h60, 0, 0, 0, 0);
        s[3] = S_RET;  t[3] = 8'hAA; x[3] = mk(8'h41, 0, 0, 0, 0);
        s[4] = S_RET;  t[4] = 8'hAA; x[4] = mk(8'h06, 1, 0, 0, 0);
        test_sequence("nest", 5, s, t, o, x);
    endtask

    task automatic test_overflow();
        logic [4:0] s [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        exp_t       x [16];
        reset8();
        for (int i = 0; i < 16; i++) begin
            s[i] = S_NOP; t[i] = '0; o[i] = '0; x[i] = '0;
        end
        s[0]  = S_LD;   t[0] = 8'h10; x[0]  = mk(8'h10, 1, 0, 0, 0);
        s[1]  = S_CALL; t[1] = 8'h20; x[1]  = mk(8'h20, 0, 0, 0, 0);
        s[2]  = S_CALL; t[2] = 8'h30; x[2]  = mk(8'h30, 0, 0, 0, 0);
        s[3]  = S_CALL; t[3] = 8'h40; x[3]  = mk(8'h40, 0, 0, 0, 0);
        s[4]  = S_CALL; t[4] = 8'h50; x[4]  = mk(8'h50, 0, 1, 0, 0);
        s[5]  = S_CALL; t[5] = 8'h60; x[5]  = mk(8'h60, 0, 1, 1, 0);
        s[6]  = S_RET;                x[6]  = mk(8'h41, 0, 0, 1, 0);
        s[7]  = S_RET;                x[7]  = mk(8'h31, 0, 0, 1, 0);
        s[8]  = S_RET;                x[8]  = mk(8'h21, 0, 0, 1, 0);
        s[9]  = S_RET;                x[9]  = mk(8'h11, 1, 0, 1, 0);
        s[10] = S_NOP;                x[10] = mk(8'h11, 1, 0, 1, 0);
        test_sequence("ovf", 11, s, t, o, x);
    endtask

    task automatic test_underflow_priority();
        logic [4:0] s [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        exp_t       x [16];
        reset8();
        for (int i = 0; i < 16; i++) begin
            s[i] = S_NOP; t[i] = '0; o[i] = '0; x[i] = '0;
        end
        s[0] = S_RET;                      t[0] = 8'h99;                x[0] = mk(8'h00, 1, 0, 0, 1);
        s[1] = S_INC | S_LD | S_BR;        t[1] = 8'h80; o[1] = 8'h03;  x[1] = mk(8'h03, 1, 0, 0, 1);
        s[2] = S_CALL;                     t[2] = 8'h50;                x[2] = mk(8'h50, 0, 0, 0, 1);
        s[3] = S_CALL | S_RET | S_LD;      t[3] = 8'h70;                x[3] = mk(8'h04, 1, 0, 0, 1);
        s[4] = S_INC | S_LD;               t[4] = 8'h22;                x[4] = mk(8'h22, 1, 0, 0, 1);
        test_sequence("unf", 5, s, t, o, x);
    endtask

    task automatic test_back_to_back_reset();
        logic [4:0] s [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        exp_t       x [16];
        // Leave state dirty, then clear asynchronously mid-cycle.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 8'h00);
        test_reset();
        for (int i = 0; i < 16; i++) begin
            s[i] = S_NOP; t[i] = '0; o[i] = '0; x[i] = '0;
        end
        s[0] = S_INC;                x[0] = mk(8'h01, 1, 0, 0, 0);
        s[1] = S_CALL; t[1] = 8'hC0; x[1] = mk(8'hC0, 0, 0, 0, 0);
        s[2] = S_RET;                x[2] = mk(8'h02, 1, 0, 0, 0);
        test_sequence("b2b", 3, s, t, o, x);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        clrn4 = 1'b1;
        clrn8 = 1'b1;
        test_reset();
        test_increment();
        test_jumps();
        test_nested_calls();
        test_overflow();
        test_underflow_priority();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter for the CPU model; successor to the 4-bit increment/clear PC. The PC width and reset vector are configurable. Beyond increment, hold and clear, it supports absolute jump, PC-relative branch, and call/return through an internal return-address stack. It sits between the control unit, which drives the command strobes, and instruction memory, which is addressed by `PC_addr`.

## Interface
Parameters:
- `AW`, 8: PC and address width, in bits (≥2).
- `DEPTH`, 4: return-stack entries (power of 2, ≥2).
- `RESET_ADDR`, 0: PC value loaded on reset; must fit in `AW` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `CLRn`  in  1  reset: asynchronous, active-low.
- `IPC`  in  1  increment PC.
- `LD`  in  1  absolute jump to `target`.
- `BR`  in  1  relative branch by `offset`.
- `CALL`  in  1  push return address, then jump to `target`.
- `RET`  in  1  pop return address into PC.
- `target`  in  AW  absolute destination.
- `offset`  in  AW  two's-complement branch displacement.
- `PC_addr`  out  AW  current PC (registered).
- `stk_empty`  out  1  return stack holds 0 entries.
- `stk_full`  out  1  return stack holds `DEPTH` entries.
- `err_ovf`  out  1  sticky flag: CALL issued while the stack was full.
- `err_unf`  out  1  sticky flag: RET issued while the stack was empty.

## Operation
- Command priority, highest first: RET > CALL > BR > LD > IPC > hold. Exactly one action executes per cycle; lower-priority strobes asserted in the same cycle are ignored.
- Hold (no strobe asserted): PC, stack and flags are unchanged.
- IPC: PC ← PC+1, modulo 2^AW. All-ones wraps to 0.
- LD: PC ← `target`.
- BR: PC ← PC + `offset`, modulo 2^AW; the result is truncated to AW bits. An offset of 0 holds the PC.
- CALL with the stack not full: push PC+1 (mod 2^AW), then PC ← `target`.
- CALL with the stack full: PC ← `target`; the push is dropped, stack contents are unchanged, and `err_ovf` ← 1.
- RET with the stack not empty: PC ← top entry; pop.
- RET with the stack empty: PC holds, the stack is unchanged, and `err_unf` ← 1.
- Error flags are sticky and clear only on reset.
- The stack is a LIFO with occupancy count 0..DEPTH. `stk_empty` = (count==0); `stk_full` = (count==DEPTH). Both flags are combinational from the registered count.
- Reset (`CLRn`=0, at any time including mid-operation):
  - `PC_addr` = RESET_ADDR.
  - count = 0, so `stk_empty`=1 and `stk_full`=0.
  - `err_ovf`=0, `err_unf`=0.
  - Stack RAM contents are don't-care.
  - All strobes are ignored while `CLRn`=0.

## Timing
- Every command takes effect at the first rising edge at which it is sampled high; `PC_addr` shows the new value immediately after that edge (1-cycle latency). There is no combinational path from the inputs to `PC_addr`.
- The stack push/pop and its count update occur on the same edge as the PC update. Stack flags reflect the new count after that edge.
- A RET immediately following a CALL (back-to-back cycles) returns the address pushed by that CALL; no bypass stall is needed.
- An asynchronous reset assertion forces all outputs to their reset values without waiting for `clk`.
- On the first edge after `CLRn` deasserts, the strobes are sampled normally.

## Structure
- Shared package/header `pc_pkg`:
  - command priority encoding, as a 3-bit one-hot-to-binary code: NOP, INC, LD, BR, CALL, RET;
  - default parameter constants.
- The top level does priority encoding, the next-PC mux, the adder for +1/offset, and the error flags.
- Sub-module `ret_stack`, parameters AW and DEPTH:
  - inputs: push, pop, din;
  - outputs: dout (top entry), empty, full;
  - internals: a register array plus a log2(DEPTH)+1-bit count, cleared by the asynchronous active-low reset.

## Test plan
- Reset and increment (AW=4, RESET_ADDR=0): assert `CLRn`=0, release, hold IPC=1 for 18 cycles. PC counts 0,1,…,15,0,1; PC wraps 15→0. Then pulse `CLRn`=0 mid-count: PC=0 immediately, without waiting for a clock edge.
- Jump and branch (AW=8): from PC=0x10, LD with `target`=0x80 gives PC=0x80. Then BR with `offset`=0xFE (−2) gives 0x7E. Then BR with `offset`=0x90 gives 0x0E (wrap).
- Nested calls (DEPTH=4): PC=0x05, CALL `target`=0x40, then CALL `target`=0x60, then RET, then RET. PC sequence: 0x40, 0x60, 0x41, 0x06. `stk_empty` returns to 1 after the second RET.
- Overflow: issue 5 CALLs with DEPTH=4. `stk_full`=1 after the 4th call. On the 5th call, PC jumps and `err_ovf`=1. Then 4 RETs return the 4 stored addresses in LIFO order.
- Underflow and priority: RET on an empty stack gives PC held and `err_unf`=1. Then assert IPC, LD and BR together: only BR executes. Then assert CALL and RET together: only RET executes.
